// File: rtl/risc_pkg.sv
// risc_pkg: shared opcode, ALU operation and instruction field definitions
package risc_pkg;
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 22;
  localparam int RS1_HI = 21;
  localparam int RS1_LO = 18;
  localparam int RS2_HI = 17;
  localparam int RS2_LO = 14;
  localparam int IMM_HI = 13;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = IMM_HI - IMM_LO + 1;
  typedef enum logic [5:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_OR   = 6'd2,
    OP_NOR  = 6'd3,
    OP_AND  = 6'd4,
    OP_ADDI = 6'd5,
    OP_ORI  = 6'd6,
    OP_ANDI = 6'd7,
    OP_BEQ  = 6'd8,
    OP_BNE  = 6'd9,
    OP_LW   = 6'd10,
    OP_SW   = 6'd11
  } opcode_e;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  typedef struct packed {
    logic [2:0] aluop;
    logic       use_imm;
    logic       uses_rs2;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       branch_ne;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational opcode to control, ALU operation and immediate decode
module instr_decode
  import risc_pkg::*;
(
  input  logic [5:0]       op,
  input  logic [3:0]       rd,
  input  logic [IMM_W-1:0] imm,
  output ctrl_t            ctrl,
  output logic [31:0]      imm_ext
);
  // undefined opcodes fall through with every control bit left at zero
  always_comb begin
    ctrl = '0;
    case (op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: ctrl.aluop = ALU_ADD;
      OP_SUB, OP_BEQ, OP_BNE:        ctrl.aluop = ALU_SUB;
      OP_OR, OP_ORI:                 ctrl.aluop = ALU_OR;
      OP_NOR:                        ctrl.aluop = ALU_NOR;
      OP_AND, OP_ANDI:               ctrl.aluop = ALU_AND;
      default:                       ctrl.illegal = 1'b1;
    endcase
    ctrl.use_imm   = op inside {OP_ADDI, OP_ORI, OP_ANDI, OP_LW, OP_SW};
    ctrl.uses_rs2  = op inside {[OP_ADD:OP_AND], OP_BEQ, OP_BNE, OP_SW};
    ctrl.regwrite  = (op <= OP_ANDI || op == OP_LW) && rd != 4'd0;
    ctrl.memread   = op == OP_LW;
    ctrl.memwrite  = op == OP_SW;
    ctrl.branch    = op inside {OP_BEQ, OP_BNE};
    ctrl.branch_ne = op == OP_BNE;
    imm_ext = op inside {OP_ORI, OP_ANDI} ? {{(32-IMM_W){1'b0}}, imm} : {{(32-IMM_W){imm[IMM_W-1]}}, imm};
  end
endmodule

// File: rtl/id_ex_issue.sv
// id_ex_issue: decode/issue stage with ID/EX pipeline register and load-use interlock
module id_ex_issue
  import risc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  rf_raddr1,
  output logic [3:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [2:0]  ex_aluop,
  output logic [31:0] ex_bus_a,
  output logic [31:0] ex_bus_b,
  output logic [31:0] ex_store_data,
  output logic [3:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_branch,
  output logic        ex_branch_ne,
  output logic        illegal
);
  ctrl_t       ctrl;
  logic [31:0] imm_ext;
  logic [3:0]  rd, rs1, rs2;
  logic        stall, load_use, accept;
  assign rd  = instr[RD_HI:RD_LO];
  assign rs1 = instr[RS1_HI:RS1_LO];
  assign rs2 = instr[RS2_HI:RS2_LO];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;
  instr_decode u_dec (
    .op      (instr[OP_HI:OP_LO]),
    .rd      (rd),
    .imm     (instr[IMM_HI:IMM_LO]),
    .ctrl    (ctrl),
    .imm_ext (imm_ext)
  );
  assign stall    = ex_valid && !ex_ready;
  assign load_use = ex_valid && ex_memread && ex_rd != 4'd0 &&
                    (ex_rd == rs1 || (ex_rd == rs2 && ctrl.uses_rs2));
  assign in_ready = !rst && !flush && !stall && !load_use;
  assign accept   = in_valid && in_ready;
  // ID/EX register: accepted instructions load, otherwise drain or hold; data survives invalidation
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_aluop      <= '0;
      ex_bus_a      <= '0;
      ex_bus_b      <= '0;
      ex_store_data <= '0;
      ex_rd         <= '0;
      ex_regwrite   <= 1'b0;
      ex_memread    <= 1'b0;
      ex_memwrite   <= 1'b0;
      ex_branch     <= 1'b0;
      ex_branch_ne  <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      illegal <= accept && ctrl.illegal;
      if (accept) begin
        ex_valid      <= 1'b1;
        ex_aluop      <= ctrl.aluop;
        ex_bus_a      <= rf_rdata1;
        ex_bus_b      <= ctrl.use_imm ? imm_ext : rf_rdata2;
        ex_store_data <= rf_rdata2;
        ex_rd         <= rd;
        ex_regwrite   <= ctrl.regwrite;
        ex_memread    <= ctrl.memread;
        ex_memwrite   <= ctrl.memwrite;
        ex_branch     <= ctrl.branch;
        ex_branch_ne  <= ctrl.branch_ne;
      end else if (flush || !stall) begin
        ex_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_issue.sv
// tb_id_ex_issue: vector table plus hazard/stall/flush/reset sequences with an issue scoreboard
module tb_id_ex_issue;
  typedef struct packed {
    logic [2:0]  aluop;
    logic [31:0] a, b, sd;
    logic [3:0]  rd;
    logic        rw, mr, mw, br, bne, ill;
  } exp_t;
  typedef struct packed {
    logic [31:0] instr, r1, r2;
    exp_t        e;
  } vec_t;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, ex_ready = 1, in_ready;
  logic [31:0] instr = 0, rf_rdata1 = 0, rf_rdata2 = 0;
  logic [3:0] rf_raddr1, rf_raddr2, ex_rd;
  logic ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_branch_ne, illegal;
  logic [2:0] ex_aluop;
  logic [31:0] ex_bus_a, ex_bus_b, ex_store_data;
  exp_t act, cur_exp = '0, snap;
  exp_t q[$];
  int checks = 0, errors = 0, nent = 0;
  logic loaded = 0;
  vec_t tv[16];
  id_ex_issue dut (
    .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_aluop(ex_aluop),
    .ex_bus_a(ex_bus_a), .ex_bus_b(ex_bus_b), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign act = {ex_aluop, ex_bus_a, ex_bus_b, ex_store_data, ex_rd,
                ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_branch_ne, illegal};
  function automatic logic [31:0] mk(int op, int rd, int rs1, int rs2, int imm);
    return {op[5:0], rd[3:0], rs1[3:0], rs2[3:0], imm[13:0]};
  endfunction
  function automatic exp_t ex(logic [2:0] alu, logic [31:0] a, logic [31:0] b, logic [31:0] sd,
                              logic [3:0] rd, logic rw, logic mr, logic mw, logic br, logic bne, logic ill);
    return {alu, a, b, sd, rd, rw, mr, mw, br, bne, ill};
  endfunction
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
    instr = i;
    rf_rdata1 = r1;
    rf_rdata2 = r2;
    cur_exp = e;
    in_valid = 1;
  endtask
  task automatic wait_ready();
    int n = 0;
    #1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got in_ready 0 want 1 within 20 cycles");
    end
  endtask
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) q.push_back(cur_exp);
    loaded <= !rst && in_valid && in_ready;
  end
  always @(negedge clk) begin : sb_check
    exp_t e, a;
    if (loaded) begin
      chk("ex_valid_on_load", ex_valid, 1);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow got unexpected entry %0h want none", act);
      end else begin
        e = q.pop_front();
        a = act;
        if (e.ill) begin
          a.a = 0; a.b = 0; a.sd = 0; a.rd = 0;
          e.a = 0; e.b = 0; e.sd = 0; e.rd = 0;
        end
        chk($sformatf("entry%0d", nent), a, e);
        nent++;
      end
    end else chk("illegal_idle", illegal, 0);
  end
  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end
  initial begin
    tv[0]  = {mk(0, 3, 1, 2, 0), 32'd5, 32'd7, ex(0, 5, 7, 7, 3, 1, 0, 0, 0, 0, 0)};
    tv[1]  = {mk(1, 1, 2, 3, 0), 32'd10, 32'd3, ex(1, 10, 3, 3, 1, 1, 0, 0, 0, 0, 0)};
    tv[2]  = {mk(2, 2, 5, 6, 0), 32'hF0F00000, 32'h00000F0F, ex(2, 32'hF0F00000, 32'h0F0F, 32'h0F0F, 2, 1, 0, 0, 0, 0, 0)};
    tv[3]  = {mk(3, 0, 1, 2, 0), 32'd1, 32'd2, ex(3, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0)};
    tv[4]  = {mk(4, 15, 3, 4, 0), 32'hFFFF, 32'h0FF0, ex(4, 32'hFFFF, 32'h0FF0, 32'h0FF0, 15, 1, 0, 0, 0, 0, 0)};
    tv[5]  = {mk(5, 6, 1, 0, 14'h3FFF), 32'd100, 32'd55, ex(0, 100, 32'hFFFFFFFF, 55, 6, 1, 0, 0, 0, 0, 0)};
    tv[6]  = {mk(6, 7, 1, 0, 14'h3FFF), 32'd100, 32'd55, ex(2, 100, 32'h3FFF, 55, 7, 1, 0, 0, 0, 0, 0)};
    tv[7]  = {mk(7, 8, 1, 0, 14'h2000), 32'd7, 32'd8, ex(4, 7, 32'h2000, 8, 8, 1, 0, 0, 0, 0, 0)};
    tv[8]  = {mk(5, 10, 1, 0, 5), 32'd1, 32'd2, ex(0, 1, 5, 2, 10, 1, 0, 0, 0, 0, 0)};
    tv[9]  = {mk(8, 0, 1, 2, 0), 32'd3, 32'd3, ex(1, 3, 3, 3, 0, 0, 0, 0, 1, 0, 0)};
    tv[10] = {mk(9, 0, 1, 2, 0), 32'd3, 32'd4, ex(1, 3, 4, 4, 0, 0, 0, 0, 1, 1, 0)};
    tv[11] = {mk(11, 5, 1, 2, 14'h3FFC), 32'd40, 32'd99, ex(0, 40, 32'hFFFFFFFC, 99, 5, 0, 0, 1, 0, 0, 0)};
    tv[12] = {mk(10, 9, 1, 0, 4), 32'd1000, 32'd0, ex(0, 1000, 4, 0, 9, 1, 1, 0, 0, 0, 0)};
    tv[13] = {mk(13, 3, 0, 0, 1), 32'd1, 32'd2, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tv[14] = {mk(63, 3, 0, 0, 1), 32'd1, 32'd2, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tv[15] = {mk(0, 1, 9, 9, 0), 32'd2, 32'd3, ex(0, 2, 3, 3, 1, 1, 0, 0, 0, 0, 0)};
    step();
    step();
    chk("reset_outputs", act, 0);
    chk("reset_ex_valid", ex_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    rst = 0;
    #1;
    chk("ready_after_reset", in_ready, 1);
    step();
    for (int i = 0; i < 16; i++) begin
      drive(tv[i].instr, tv[i].r1, tv[i].r2, tv[i].e);
      #1;
      chk($sformatf("raddr%0d", i), {rf_raddr1, rf_raddr2}, {tv[i].instr[21:18], tv[i].instr[17:14]});
      wait_ready();
      step();
    end
    in_valid = 0;
    step();
    drive(mk(10, 4, 1, 0, 8), 200, 0, ex(0, 200, 8, 0, 4, 1, 1, 0, 0, 0, 0));
    wait_ready();
    step();
    drive(mk(0, 5, 4, 1, 0), 11, 22, ex(0, 11, 22, 22, 5, 1, 0, 0, 0, 0, 0));
    #1;
    chk("loaduse_rs1_block", in_ready, 0);
    step();
    chk("loaduse_bubble", ex_valid, 0);
    chk("loaduse_release", in_ready, 1);
    step();
    drive(mk(10, 4, 1, 0, 0), 300, 0, ex(0, 300, 0, 0, 4, 1, 1, 0, 0, 0, 0));
    wait_ready();
    step();
    drive(mk(2, 5, 1, 4, 0), 1, 2, ex(2, 1, 2, 2, 5, 1, 0, 0, 0, 0, 0));
    #1;
    chk("loaduse_rs2_block", in_ready, 0);
    drive(mk(6, 6, 1, 4, 1), 8, 9, ex(2, 8, 1, 9, 6, 1, 0, 0, 0, 0, 0));
    #1;
    chk("loaduse_ori_rs2_ignored", in_ready, 1);
    step();
    drive(mk(10, 0, 1, 0, 0), 12, 13, ex(0, 12, 0, 13, 0, 0, 1, 0, 0, 0, 0));
    wait_ready();
    step();
    drive(mk(0, 5, 0, 0, 0), 0, 0, ex(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0));
    #1;
    chk("lw_r0_no_stall", in_ready, 1);
    step();
    in_valid = 0;
    step();
    drive(mk(0, 3, 1, 2, 0), 5, 7, ex(0, 5, 7, 7, 3, 1, 0, 0, 0, 0, 0));
    wait_ready();
    step();
    snap = act;
    ex_ready = 0;
    drive(mk(1, 1, 2, 3, 0), 9, 4, ex(1, 9, 4, 4, 1, 1, 0, 0, 0, 0, 0));
    #1;
    chk("stall_in_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall_hold%0d", k), act, snap);
      chk($sformatf("stall_valid%0d", k), ex_valid, 1);
      chk($sformatf("stall_ready%0d", k), in_ready, 0);
    end
    ex_ready = 1;
    #1;
    chk("stall_release", in_ready, 1);
    step();
    in_valid = 0;
    step();
    drive(mk(10, 4, 1, 0, 0), 7, 0, ex(0, 7, 0, 0, 4, 1, 1, 0, 0, 0, 0));
    wait_ready();
    step();
    ex_ready = 0;
    flush = 1;
    drive(mk(0, 5, 4, 1, 0), 1, 1, ex(0, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0));
    #1;
    chk("flush_in_ready", in_ready, 0);
    step();
    chk("flush_kill", ex_valid, 0);
    ex_ready = 1;
    drive(mk(13, 0, 0, 0, 0), 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    #1;
    chk("flush_drop_illegal", in_ready, 0);
    step();
    chk("flush_no_illegal", illegal, 0);
    chk("flush_no_valid", ex_valid, 0);
    flush = 0;
    wait_ready();
    step();
    ex_ready = 0;
    in_valid = 0;
    step();
    chk("illegal_one_cycle", illegal, 0);
    chk("illegal_held_ctrl", {ex_valid, ex_aluop, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_branch_ne}, 9'b1_000_00000);
    ex_ready = 1;
    step();
    drive(mk(0, 3, 1, 2, 0), 5, 7, ex(0, 5, 7, 7, 3, 1, 0, 0, 0, 0, 0));
    wait_ready();
    step();
    ex_ready = 0;
    drive(mk(1, 1, 2, 3, 0), 9, 4, ex(1, 9, 4, 4, 1, 1, 0, 0, 0, 0, 0));
    rst = 1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    step();
    chk("rst_outputs", act, 0);
    chk("rst_valid", ex_valid, 0);
    chk("rst_in_ready_hold", in_ready, 0);
    step();
    chk("rst_in_ready_hold2", in_ready, 0);
    in_valid = 0;
    ex_ready = 1;
    rst = 0;
    #1;
    chk("rst_release", in_ready, 1);
    step();
    step();
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_issue.md
ID_EX_ISSUE -- requirements
Module: id_ex_issue

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port instr  input  32  instruction: op[31:26], rd[25:22], rs1[21:18], rs2[17:14], imm[13:0].
REQ-004 SHALL have port in_valid  input  1  instr valid this cycle.
REQ-005 SHALL have port in_ready  output  1  instr accepted when in_valid && in_ready.
REQ-006 SHALL have ports rf_raddr1/rf_raddr2  output  4  register-file read addresses, combinationally = rs1/rs2.
REQ-007 SHALL have ports rf_rdata1/rf_rdata2  input  32  register-file read data, same cycle.
REQ-008 SHALL have port flush  input  1  kill the held EX entry and the current input.
REQ-009 SHALL have port ex_ready  input  1  EX stage consumes the held entry this cycle.
REQ-010 SHALL have ports ex_valid 1, ex_aluop 3, ex_bus_a 32, ex_bus_b 32, ex_store_data 32, ex_rd 4, ex_regwrite 1, ex_memread 1, ex_memwrite 1, ex_branch 1, ex_branch_ne 1 -- all outputs, all registered, driving the ALU (ALUOP/BusA/BusB) and later stages.
REQ-011 SHALL have port illegal  output  1  registered one-cycle pulse on acceptance of an undefined opcode.

Function
REQ-012 SHALL decode op: 0 ADD, 1 SUB, 2 OR, 3 NOR, 4 AND (R-type, bus_b=rdata2); 5 ADDI, 10 LW, 11 SW (bus_b=sign-ext imm); 6 ORI, 7 ANDI (bus_b=zero-ext imm); 8 BEQ, 9 BNE (SUB, bus_b=rdata2).
REQ-013 SHALL map ALUOP: add 000, sub 001, or 010, nor 011, and 100; ADDI/LW/SW use 000, ORI 010, ANDI 100, BEQ/BNE 001.
REQ-014 SHALL drive ex_bus_a = rdata1 for all ops; ex_store_data = rdata2 (SW only meaningful).
REQ-015 SHALL set regwrite for ops 0-7 and 10 when rd != 0; memread for LW; memwrite for SW; branch for BEQ/BNE; branch_ne for BNE only.
REQ-016 SHALL treat op >= 12 as illegal: entry loads with ex_valid=1, all control bits 0, aluop 000, and illegal pulses.
REQ-017 SHALL keep the EX register when ex_valid && !ex_ready (stall); in_ready=0 then.
REQ-018 SHALL detect load-use: ex_valid && ex_memread && ex_rd!=0 && (ex_rd==rs1 || (ex_rd==rs2 && op uses rs2: R-type, BEQ, BNE, SW)) forces in_ready=0.
REQ-019 SHALL, on load-use with ex_ready=1, load a bubble (ex_valid=0) next cycle; the instruction is accepted the following cycle.
REQ-020 SHALL load a new entry with latency 1 cycle when accepted; otherwise if ex_ready load ex_valid=0.
REQ-021 SHALL on flush force ex_valid=0 next cycle, drop the current input (in_ready=0), suppress illegal; flush overrides stall and load-use.
REQ-022 SHALL keep data fields unchanged when ex_valid goes 0 (only ex_valid qualifies).

Reset
REQ-023 SHALL, while rst is high at a clk edge, clear ex_valid, illegal and all control bits, and zero ex_aluop, ex_bus_a, ex_bus_b, ex_store_data, ex_rd.
REQ-024 SHALL hold in_ready=0 during rst; reset mid-stall discards the held entry.

Structure
REQ-025 SHALL place opcode constants, ALUOP constants (ADD..AND) and field bit positions in shared package risc_pkg.
REQ-026 SHALL put combinational op-to-control/ALUOP/immediate decode in sub-module instr_decode; hazard and pipeline register logic stay here.

Verification
REQ-027 ADD r3,r1,r2 with rdata1=5, rdata2=7 -> next cycle ex_valid=1, aluop=000, bus_a=5, bus_b=7, rd=3, regwrite=1.
REQ-028 ADDI imm=0x3FFF, ORI imm=0x3FFF -> bus_b=0xFFFFFFFF then 0x00003FFF; aluop 000 then 010.
REQ-029 LW r4 followed by ADD r5,r4,r1, ex_ready=1 -> in_ready=0 one cycle, bubble (ex_valid=0), ADD issues next cycle; LW r0 causes no stall.
REQ-030 ex_ready=0 for 3 cycles with in_valid=1 -> EX outputs stable, in_ready=0, no instruction lost or duplicated.
REQ-031 flush asserted together with stall and load-use -> ex_valid=0 next cycle, input dropped; op=13 accepted -> illegal=1 one cycle, all control bits 0.
REQ-032 rst asserted while stalled with a valid entry -> next cycle all outputs at reset values, in_ready=0 until rst drops.
